serial_ripple_subtractor: RTL and testbench



---
 rtl/serial_arith_pkg.sv | 15 +
 rtl/full_subtractor.sv | 20 ++
 rtl/serial_ripple_subtractor.sv | 117 +++++++++++
 tb/tb_serial_ripple_subtractor.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Purpose: shared FSM state encoding and width limits for the bit-serial arithmetic blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_arith_pkg;

    // Upper bound on the operand width supported by the serial arithmetic units.
    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage : serial_arith_pkg

// File: rtl/full_subtractor.sv
// Purpose: combinational 1-bit full subtractor, d = a - b - bin.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: a minuend bit, b subtrahend bit, bin borrow-in, d difference bit, bout borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign d     = w_axb ^ bin;
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    assign bout  = (~a & b) | (~w_axb & bin);

endmodule : full_subtractor

// File: rtl/serial_ripple_subtractor.sv
// Purpose: bit-serial D = A - B - bin0, LSB first, one full-subtractor stage reused per cycle.
// Latency: out_valid rises WIDTH cycles after the accepting edge; one op per WIDTH+2 cycles.
// Backpressure: result held in DONE indefinitely until out_ready; in_ready low while BUSY/DONE.
// Ports: clk, rst_n (sync active-low), in_valid/in_ready + a, b, bin0 on the input side;
//        out_valid/out_ready + d, bout on the output side.
// Option: define SERIAL_SUB_SAT_EN to clamp d to 0 on final borrow (bout still reports 1).
module serial_ripple_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int              CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    state_t            r_state;
    logic [WIDTH-1:0]  r_sa;
    logic [WIDTH-1:0]  r_sb;
    logic [WIDTH-1:0]  r_res;
    logic              r_borrow;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_d;
    logic              r_bout;

    logic              w_dbit;
    logic              w_bout;
    logic [WIDTH-1:0]  w_res_next;

    full_subtractor u_fs (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .bin  (r_borrow),
        .d    (w_dbit),
        .bout (w_bout)
    );

    // After WIDTH right-shifts the first (LSB) difference bit lands at bit 0.
    assign w_res_next = {w_dbit, r_res[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sa        <= '0;
            r_sb        <= '0;
            r_res       <= '0;
            r_borrow    <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_d         <= '0;
            r_bout      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sa       <= a;
                        r_sb       <= b;
                        r_borrow   <= bin0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    r_sa     <= r_sa >> 1;
                    r_sb     <= r_sb >> 1;
                    r_borrow <= w_bout;
                    r_res    <= w_res_next;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_MAX) begin
`ifdef SERIAL_SUB_SAT_EN
                        r_d <= w_bout ? '0 : w_res_next;
`else
                        r_d <= w_res_next;
`endif
                        r_bout      <= w_bout;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // in_ready rises only after the handoff edge: no same-cycle re-accept.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign d         = r_d;
    assign bout      = r_bout;

endmodule : serial_ripple_subtractor

// File: tb/tb_serial_ripple_subtractor.sv
module tb_serial_ripple_subtractor;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin0;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;

    int checks = 0;
    int errors = 0;

    serial_ripple_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin0      (bin0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then step off it before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for out_valid, return number of edges since the accepting edge.
    task automatic wait_result(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic accept(input logic [3:0] ta, input logic [3:0] tb_, input logic tbin);
        a = ta; b = tb_; bin0 = tbin; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tb_,
                          input logic tbin, input logic [3:0] exp_d, input logic exp_b);
        int n;
        check({tag, "_rdy_before"}, in_ready, 1);
        accept(ta, tb_, tbin);
        check({tag, "_busy_rdy"}, in_ready, 0);
        wait_result(n);
        check({tag, "_latency"}, n, WIDTH);
        check({tag, "_d"}, d, exp_d);
        check({tag, "_bout"}, bout, exp_b);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_vld_clr"}, out_valid, 0);
        check({tag, "_rdy_back"}, in_ready, 1);
    endtask

    logic [3:0] exp_sat_d;
    logic [3:0] held_d;
    int         lat;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin0 = 1'b0;

        // 1. reset
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_d", d, 0);
        check("rst_bout", bout, 0);

        // 2. basic subtraction
        run_op("op9m3", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0);

        // 3. underflow (wraps, or clamps to 0 in the saturating build)
`ifdef SERIAL_SUB_SAT_EN
        exp_sat_d = 4'd0;
`else
        exp_sat_d = 4'd10;
`endif
        run_op("op3m9", 4'd3, 4'd9, 1'b0, exp_sat_d, 1'b1);

        // 4. borrow-in underflow and max minus zero
`ifdef SERIAL_SUB_SAT_EN
        exp_sat_d = 4'd0;
`else
        exp_sat_d = 4'd15;
`endif
        run_op("op5m5b", 4'd5, 4'd5, 1'b1, exp_sat_d, 1'b1);
        run_op("op15m0", 4'd15, 4'd0, 1'b0, 4'd15, 1'b0);
        run_op("op0m0b", 4'd0, 4'd0, 1'b1, exp_sat_d, 1'b1);

        // 5. in_valid held during BUSY is ignored; backpressure holds the result
        accept(4'd9, 4'd3, 1'b0);
        a = 4'd1; b = 4'd1; in_valid = 1'b1;
        wait_result(lat);
        check("hold_latency", lat, WIDTH);
        check("hold_d", d, 6);
        check("hold_bout", bout, 0);
        in_valid = 1'b0;
        held_d = d;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_d", d, 6);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_vld", out_valid, 0);
        check("bp_release_rdy", in_ready, 1);
        check("d_kept_after_done", d, 6);

        // 6. reset in the middle of BUSY discards the op
        accept(4'd9, 4'd3, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_rdy", in_ready, 1);
        check("midrst_d", d, 0);
        for (int i = 0; i < 6; i++) begin
            check("midrst_no_vld", out_valid, 0);
            tick();
        end
        run_op("op7m2", 4'd7, 4'd2, 1'b0, 4'd5, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serial_ripple_subtractor
